axis_video_sink: RTL and testbench

Synthesizable AXI4-Stream receiver for 8-bit video frames: the consuming end of the stream the CLAHE pipeline emits (TUSER = start of frame, TLAST = end of line). It sits downstream of `CLAHE_AXI` on the board and in system benches. It generates TREADY, with optional pseudo-random backpressure, and tracks row/column position. It checks frame geometry against the configured size and reports a per-frame checksum and error status.

---
 rtl/axis_video_sink.sv | 137 +++++++++++++
 tb/tb_axis_video_sink.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_sink.sv
// AXI4-Stream 8-bit video sink: frame geometry checking, per-frame Fletcher checksum, error status.
// Optional pseudo-random backpressure is compiled in with `define AXIS_SINK_BACKPRESSURE_EN.
module axis_video_sink (
    input  logic        ACLK_in,
    input  logic        ARST_in,
    input  logic [7:0]  TDATA_in,
    input  logic        TSTRB_in,
    input  logic        TLAST_in,
    input  logic        TVALID_in,
    input  logic        TUSER_in,
    output logic        TREADY_out,
    input  logic        sink_en,
    input  logic [10:0] width_in,
    input  logic [10:0] height_in,
    output logic        frame_done,
    output logic [31:0] frame_checksum,
    output logic [2:0]  err_status,
    output logic [15:0] frame_cnt
);
    localparam int unsigned CW = 11;
    localparam int unsigned SW = 16;

    typedef enum logic [0:0] {WAIT_SOF, ACTIVE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_col, r_row, r_w, r_h;
    logic [SW-1:0]   r_s1, r_s2;
    logic [2:0]      r_err;
    logic            r_tready, r_frame_done;
    logic [31:0]     r_checksum;
    logic [2:0]      r_err_status;
    logic [15:0]     r_frame_cnt;

    logic            w_unused;
    logic            w_rdy_n;
    logic            w_acc, w_pix, w_restart, w_cur_last, w_eol_at, w_le, w_done;
    logic [CW-1:0]   w_cw, w_ch, w_ccol, w_crow, w_col_n, w_row_n;
    logic [SW-1:0]   w_cs1, w_cs2, w_s1, w_s2;
    logic [2:0]      w_cerr, w_err;

    assign w_unused = TSTRB_in;

`ifdef AXIS_SINK_BACKPRESSURE_EN
    logic [15:0] r_lfsr;

    // Galois LFSR; a zero low nibble stalls the following cycle
    always_ff @(posedge ACLK_in) begin
        if (ARST_in) r_lfsr <= 16'hACE1;
        else         r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
    assign w_rdy_n = sink_en & (r_lfsr[3:0] != 4'h0);
`else
    assign w_rdy_n = sink_en;
`endif

    // Per-beat datapath: pick the frame context (fresh on SOF/restart), then advance it
    always_comb begin
        w_acc      = TVALID_in & r_tready;
        w_cur_last = (r_state == ACTIVE) && (TLAST_in || (r_col == r_w - CW'(1)))
                     && (r_row == r_h - CW'(1));
        w_restart  = TUSER_in && ((r_state == WAIT_SOF)
                     || (((r_col != '0) || (r_row != '0)) && !w_cur_last));
        w_pix      = (r_state == ACTIVE) || TUSER_in;
        w_cw   = r_w;
        w_ch   = r_h;
        w_ccol = r_col;
        w_crow = r_row;
        w_cs1  = r_s1;
        w_cs2  = r_s2;
        w_cerr = r_err;
        if (w_restart) begin
            w_cw   = (width_in  == '0) ? CW'(1) : width_in;
            w_ch   = (height_in == '0) ? CW'(1) : height_in;
            w_ccol = '0;
            w_crow = '0;
            w_cs1  = '0;
            w_cs2  = '0;
            w_cerr = (r_state == ACTIVE) ? 3'b100 : 3'b000;
        end
        w_s1     = w_cs1 + SW'(TDATA_in);
        w_s2     = w_cs2 + w_s1;
        w_eol_at = (w_ccol == w_cw - CW'(1));
        w_le     = TLAST_in | w_eol_at;
        w_err    = w_cerr | {1'b0, ~TLAST_in & w_eol_at, TLAST_in & ~w_eol_at};
        w_done   = w_le && (w_crow == w_ch - CW'(1));
        w_col_n  = w_le ? '0 : w_ccol + CW'(1);
        w_row_n  = w_le ? w_crow + CW'(1) : w_crow;
    end

    // Frame-tracking FSM with registered outputs
    always_ff @(posedge ACLK_in) begin
        if (ARST_in) begin
            r_state      <= WAIT_SOF;
            r_col        <= '0;
            r_row        <= '0;
            r_w          <= '0;
            r_h          <= '0;
            r_s1         <= '0;
            r_s2         <= '0;
            r_err        <= '0;
            r_tready     <= 1'b0;
            r_frame_done <= 1'b0;
            r_checksum   <= '0;
            r_err_status <= '0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_tready     <= w_rdy_n;
            if (w_acc && w_pix) begin
                r_w   <= w_cw;
                r_h   <= w_ch;
                r_s1  <= w_s1;
                r_s2  <= w_s2;
                r_err <= w_err;
                if (w_done) begin
                    r_state      <= WAIT_SOF;
                    r_col        <= '0;
                    r_row        <= '0;
                    r_frame_done <= 1'b1;
                    r_checksum   <= {w_s2, w_s1};
                    r_err_status <= w_err;
                    r_frame_cnt  <= r_frame_cnt + 16'd1;
                end else begin
                    r_state <= ACTIVE;
                    r_col   <= w_col_n;
                    r_row   <= w_row_n;
                end
            end
        end
    end

    assign TREADY_out     = r_tready;
    assign frame_done     = r_frame_done;
    assign frame_checksum = r_checksum;
    assign err_status     = r_err_status;
    assign frame_cnt      = r_frame_cnt;
endmodule

// File: tb/tb_axis_video_sink.sv
// Directed bench for axis_video_sink; expected frame results are queued at drive time, checked on frame_done.
module tb_axis_video_sink;
    logic        clk = 1'b0;
    logic        ARST_in, TSTRB_in, TLAST_in, TVALID_in, TUSER_in, sink_en;
    logic [7:0]  TDATA_in;
    logic [10:0] width_in, height_in;
    logic        TREADY_out, frame_done;
    logic [31:0] frame_checksum;
    logic [2:0]  err_status;
    logic [15:0] frame_cnt;

    int n_vec = 0, n_err = 0, exp_cnt = 0, n_done = 0, n_push = 0;
    logic [15:0] m_s1, m_s2;
    logic [31:0] q_ck[$];
    logic [2:0]  q_err[$];
    logic [15:0] q_cnt[$];

    always #5 clk = ~clk;

    axis_video_sink dut (
        .ACLK_in(clk), .ARST_in(ARST_in), .TDATA_in(TDATA_in), .TSTRB_in(TSTRB_in),
        .TLAST_in(TLAST_in), .TVALID_in(TVALID_in), .TUSER_in(TUSER_in),
        .TREADY_out(TREADY_out), .sink_en(sink_en), .width_in(width_in),
        .height_in(height_in), .frame_done(frame_done), .frame_checksum(frame_checksum),
        .err_status(err_status), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_s1 = '0;
        m_s2 = '0;
    endtask

    // Drive one beat and wait for acceptance; ex >= 0 marks the frame's final beat with that err_status
    task automatic beat(input logic [7:0] d, input logic u, input logic l, input int ex = -1);
        int g = 0;
        m_s1 = m_s1 + 16'(d);
        m_s2 = m_s2 + m_s1;
        if (ex >= 0) begin
            exp_cnt++;
            n_push++;
            q_ck.push_back({m_s2, m_s1});
            q_err.push_back(3'(ex));
            q_cnt.push_back(16'(exp_cnt));
        end
        TVALID_in = 1'b1; TDATA_in = d; TUSER_in = u; TLAST_in = l;
        while (TREADY_out !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("accept_in_time", 32'(g < 200), 32'd1);
        @(negedge clk);
        TVALID_in = 1'b0; TUSER_in = 1'b0; TLAST_in = 1'b0;
    endtask

    task automatic frame(input int w, input int h, input int base, input bit cst, input int stop);
        logic [7:0] d;
        width_in  = 11'(w);
        height_in = 11'(h);
        model_clear();
        for (int i = 0; i < stop; i++) begin
            d = cst ? 8'(base) : 8'(base + i);
            beat(d, i == 0, (i % w) == w - 1, (i == w * h - 1) ? 0 : -1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every frame_done pops one expected frame result
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            n_done++;
            n_vec++;
            assert (q_ck.size() != 0) else begin
                n_err++;
                $error("FAIL done_expected: queue size %0d expected >0", q_ck.size());
            end
            if (q_ck.size() != 0) begin
                chk("checksum", frame_checksum, q_ck.pop_front());
                chk("err_status", 32'(err_status), 32'(q_err.pop_front()));
                chk("frame_cnt", 32'(frame_cnt), 32'(q_cnt.pop_front()));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARST_in = 1'b1; sink_en = 1'b1; TSTRB_in = 1'b1; TLAST_in = 1'b0;
        TVALID_in = 1'b0; TUSER_in = 1'b0; TDATA_in = '0;
        width_in = 11'd4; height_in = 11'd2;
        model_clear();
        idle(3);
        chk("rst_tready", 32'(TREADY_out), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_checksum", frame_checksum, 32'd0);
        chk("rst_err", 32'(err_status), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        ARST_in = 1'b0;
        idle(1);
        chk("tready_after_rst", 32'(TREADY_out), 32'd1);

        // Junk before SOF is discarded, then clean 4x2 frame 1..8
        beat(8'h33, 1'b0, 1'b0);
        beat(8'h44, 1'b0, 1'b1);
        frame(4, 2, 1, 1'b0, 8);
        chk("t1_done_pulse", 32'(frame_done), 32'd1);
        chk("t1_checksum_const", frame_checksum, 32'h0078_0024);
        idle(1);
        chk("t1_done_low", 32'(frame_done), 32'd0);

        // Same frame with TVALID gaps
        model_clear();
        beat(1, 1, 0); beat(2, 0, 0); idle(3);
        beat(3, 0, 0); beat(4, 0, 1); beat(5, 0, 0); idle(3);
        beat(6, 0, 0); beat(7, 0, 0); beat(8, 0, 1, 0);
        chk("t2_done_pulse", 32'(frame_done), 32'd1);
        chk("t2_checksum_const", frame_checksum, 32'h0078_0024);
        idle(1);
        chk("t2_done_low", 32'(frame_done), 32'd0);

        // Early EOL on pixel 3; frame completes after 7 beats
        model_clear();
        beat(1, 1, 0); beat(2, 0, 0); beat(3, 0, 1);
        beat(4, 0, 0); beat(5, 0, 0); beat(6, 0, 0); beat(7, 0, 1, 1);
        chk("t3_done_pulse", 32'(frame_done), 32'd1);

        // SOF reasserted at pixel 6 restarts the frame
        model_clear();
        beat(9, 1, 0); beat(10, 0, 0); beat(11, 0, 0); beat(12, 0, 1); beat(13, 0, 0);
        chk("t4_no_done_abort", 32'(frame_done), 32'd0);
        model_clear();
        beat(1, 1, 0); beat(2, 0, 0); beat(3, 0, 0); beat(4, 0, 1);
        beat(5, 0, 0); beat(6, 0, 0); beat(7, 0, 0); beat(8, 0, 1, 4);
        chk("t4_checksum_const", frame_checksum, 32'h0078_0024);

        // Missing EOL on both lines
        model_clear();
        for (int i = 1; i <= 8; i++) beat(8'(i), i == 1, 1'b0, (i == 8) ? 2 : -1);

        // 1x1 frame completes on its SOF beat (back-to-back with previous frame_done)
        width_in = 11'd1; height_in = 11'd1;
        model_clear();
        beat(8'h5A, 1'b1, 1'b1, 0);
        chk("t6_checksum_const", frame_checksum, 32'h005A_005A);

        // sink_en low mid-frame: TREADY drops, held data never sampled
        width_in = 11'd4; height_in = 11'd2;
        model_clear();
        beat(1, 1, 0); beat(2, 0, 0); beat(3, 0, 0);
        sink_en = 1'b0;
        idle(1);
        chk("sink_en_tready_low", 32'(TREADY_out), 32'd0);
        TVALID_in = 1'b1; TDATA_in = 8'hAA; TUSER_in = 1'b1;
        idle(4);
        chk("sink_en_tready_held", 32'(TREADY_out), 32'd0);
        TVALID_in = 1'b0; TUSER_in = 1'b0;
        sink_en = 1'b1;
        beat(4, 0, 1); beat(5, 0, 0); beat(6, 0, 0); beat(7, 0, 0); beat(8, 0, 1, 0);
        chk("t7_checksum_const", frame_checksum, 32'h0078_0024);

        // Full-width all-0xFF frames, twice
        frame(1280, 3, 8'hFF, 1'b1, 1280 * 3);
        chk("t8a_s1", 32'(frame_checksum[15:0]), 32'h0000_F100);
        frame(1280, 3, 8'hFF, 1'b1, 1280 * 3);
        chk("t8b_s1", 32'(frame_checksum[15:0]), 32'h0000_F100);
        chk("t8_cnt", 32'(frame_cnt), 32'd9);

        // Reset at pixel 500 of a 1280-wide frame
        frame(1280, 3, 7, 1'b0, 499);
        ARST_in = 1'b1;
        idle(1);
        chk("mid_rst_done", 32'(frame_done), 32'd0);
        chk("mid_rst_checksum", frame_checksum, 32'd0);
        chk("mid_rst_err", 32'(err_status), 32'd0);
        chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        chk("mid_rst_tready", 32'(TREADY_out), 32'd0);
        ARST_in = 1'b0;
        exp_cnt = 0;
        idle(1);
        frame(1280, 3, 7, 1'b0, 1280 * 3);
        chk("post_rst_cnt", 32'(frame_cnt), 32'd1);

        idle(3);
        chk("sb_empty", 32'(q_ck.size()), 32'd0);
        chk("done_total", 32'(n_done), 32'(n_push));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
